// File: rtl/abr_sampler_ctrl.sv
// Sampler controller: pulls source words in blocks of BLOCK_WORDS, requests a
// new squeeze block between blocks, and writes coefficient groups out of the
// sample buffer until NUM_WRITES groups are stored. After that the buffer is
// flushed and done_o is pulsed.
//
// Source handshake: a word moves on any cycle where src_req_o and src_valid_i
// are both high. src_req_o is combinational and never depends on src_valid_i.
module abr_sampler_ctrl #(
    parameter int NUM_RD      = 4,
    parameter int NUM_COEFF   = 256,
    parameter int BLOCK_WORDS = 21,
    localparam int NUM_WRITES = NUM_COEFF / NUM_RD,
    localparam int ADDR_W     = $clog2(NUM_WRITES),
    localparam int WCNT_W     = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              zeroize,
    input  logic              start_i,
    output logic              src_req_o,
    input  logic              src_valid_i,
    output logic              squeeze_next_o,
    input  logic              sqz_ack_i,
    input  logic              buf_full_i,
    input  logic              buf_valid_i,
    output logic              buf_flush_o,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        state_dbg_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] SQZ   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WRITES - 1);

    logic [2:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sqz_first_q, sqz_first_d;
    logic              xfer;

    // Output decode; zeroize masks every strobe in its cycle.
    always_comb begin
        src_req_o      = (state_q == RUN) & ~buf_full_i & ~zeroize;
        xfer           = src_req_o & src_valid_i;
        dst_we_o       = buf_valid_i & ((state_q == RUN) | (state_q == SQZ)) & ~zeroize;
        squeeze_next_o = sqz_first_q & (state_q == SQZ) & ~zeroize;
        buf_flush_o    = rst_b & ((state_q == FLUSH) | zeroize);
        done_o         = (state_q == DONE) & ~zeroize;
        busy_o         = (state_q != IDLE);
        dst_addr_o     = addr_q;
        state_dbg_o    = state_q;
    end

    // Next-state and counter update; the last write overrides a block wrap.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        sqz_first_d = 1'b0;
        if (zeroize) begin
            state_d = IDLE;
            wcnt_d  = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = RUN;
                        wcnt_d  = '0;
                        addr_d  = '0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (wcnt_q == WCNT_LAST) begin
                            wcnt_d      = '0;
                            state_d     = SQZ;
                            sqz_first_d = 1'b1;
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                end
                SQZ: begin
                    if (sqz_ack_i) begin
                        state_d = RUN;
                    end
                end
                FLUSH:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            // Address saturates at the last group so it never wraps.
            if (dst_we_o) begin
                if (addr_q == ADDR_LAST) begin
                    state_d     = FLUSH;
                    sqz_first_d = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            addr_q      <= '0;
            sqz_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            sqz_first_q <= sqz_first_d;
        end
    end

endmodule

// File: tb/tb_abr_sampler_ctrl.sv
// Directed bench for abr_sampler_ctrl with default parameters (64 writes,
// 21-word blocks).
module tb_abr_sampler_ctrl;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       zeroize;
    logic       start_i;
    logic       src_req_o;
    logic       src_valid_i;
    logic       squeeze_next_o;
    logic       sqz_ack_i;
    logic       buf_full_i;
    logic       buf_valid_i;
    logic       buf_flush_o;
    logic       dst_we_o;
    logic [5:0] dst_addr_o;
    logic       busy_o;
    logic       done_o;
    logic [2:0] state_dbg_o;

    int n_checks = 0;
    int n_fail   = 0;

    abr_sampler_ctrl dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .zeroize        (zeroize),
        .start_i        (start_i),
        .src_req_o      (src_req_o),
        .src_valid_i    (src_valid_i),
        .squeeze_next_o (squeeze_next_o),
        .sqz_ack_i      (sqz_ack_i),
        .buf_full_i     (buf_full_i),
        .buf_valid_i    (buf_valid_i),
        .buf_flush_o    (buf_flush_o),
        .dst_we_o       (dst_we_o),
        .dst_addr_o     (dst_addr_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .state_dbg_o    (state_dbg_o)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_writes;
    int wcnt;
    int sqz_cyc;
    int cyc;
    bit in_sqz;

    initial begin
        rst_b = 1'b0; zeroize = 1'b0; start_i = 1'b0; src_valid_i = 1'b0;
        sqz_ack_i = 1'b0; buf_full_i = 1'b0; buf_valid_i = 1'b0;

        // Reset state.
        #2;
        check("rst_src_req", src_req_o, 0);
        check("rst_squeeze", squeeze_next_o, 0);
        check("rst_flush", buf_flush_o, 0);
        check("rst_we", dst_we_o, 0);
        check("rst_addr", dst_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;

        // An ack outside SQZ does nothing.
        sqz_ack_i = 1'b1;
        tick();
        sqz_ack_i = 1'b0;
        #1 check("idle_ack_busy", busy_o, 0);

        // Block boundary, buf_full backpressure and squeeze handshake.
        start_i = 1'b1;
        #1 check("a_idle_req", src_req_o, 0);
        tick();
        start_i = 1'b0; src_valid_i = 1'b1; buf_full_i = 1'b1;
        #1 check("a_full_req", src_req_o, 0);
        check("a_run_busy", busy_o, 1);
        tick();
        buf_full_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 check("a_blk_req", src_req_o, 1);
            tick();
        end
        #1 check("a_21st_req", src_req_o, 1);
        check("a_21st_sqz", squeeze_next_o, 0);
        tick();
        #1 check("a_sqz1_pulse", squeeze_next_o, 1);
        check("a_sqz1_req", src_req_o, 0);
        tick();
        #1 check("a_sqz2_pulse", squeeze_next_o, 0);
        check("a_sqz2_req", src_req_o, 0);
        tick();
        sqz_ack_i = 1'b1;
        #1 check("a_ack_req", src_req_o, 0);
        tick();
        sqz_ack_i = 1'b0;
        #1 check("a_resume_req", src_req_o, 1);
        check("a_resume_sqz", squeeze_next_o, 0);
        repeat (20) tick();
        #1 check("a_blk2_last_req", src_req_o, 1);
        check("a_blk2_last_sqz", squeeze_next_o, 0);
        tick();
        #1 check("a_blk2_sqz", squeeze_next_o, 1);
        tick();
        zeroize = 1'b1;
        #1 check("a_zero_flush", buf_flush_o, 1);
        tick();
        zeroize = 1'b0;
        #1 check("a_zero_idle", busy_o, 0);

        // Full job with a modelled source, squeeze responder and buffer.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 0; exp_writes = 0; wcnt = 0; in_sqz = 1'b0; sqz_cyc = 0;
        while (exp_writes < 64 && cyc < 1000) begin
            buf_valid_i = ((cyc % 4) != 3);
            sqz_ack_i   = in_sqz && (sqz_cyc == 2);
            #1;
            check("job_src_req", src_req_o, {31'd0, !in_sqz});
            check("job_squeeze", squeeze_next_o, {31'd0, in_sqz && (sqz_cyc == 0)});
            check("job_we", dst_we_o, {31'd0, buf_valid_i});
            if (buf_valid_i) check("job_addr", dst_addr_o, exp_writes);
            check("job_busy", busy_o, 1);
            check("job_flush", buf_flush_o, 0);
            if (buf_valid_i) exp_writes++;
            if (in_sqz) begin
                if (sqz_ack_i) begin
                    in_sqz = 1'b0;
                    wcnt   = 0;
                end else begin
                    sqz_cyc++;
                end
            end else begin
                wcnt++;
                if (wcnt == 21) begin
                    in_sqz  = 1'b1;
                    sqz_cyc = 0;
                    wcnt    = 0;
                end
            end
            tick();
            cyc++;
        end
        check("job_write_count", exp_writes, 64);
        sqz_ack_i = 1'b0; buf_valid_i = 1'b1;
        #1 check("tail_flush_we", dst_we_o, 0);
        check("tail_flush", buf_flush_o, 1);
        check("tail_flush_done", done_o, 0);
        check("tail_flush_req", src_req_o, 0);
        tick();
        #1 check("tail_done_we", dst_we_o, 0);
        check("tail_done_flush", buf_flush_o, 0);
        check("tail_done", done_o, 1);
        check("tail_done_busy", busy_o, 1);
        tick();
        #1 check("tail_idle_we", dst_we_o, 0);
        check("tail_idle_done", done_o, 0);
        check("tail_idle_busy", busy_o, 0);
        tick();
        buf_valid_i = 1'b0;

        // Zeroize at address 30, with a stray start in RUN.
        src_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0; buf_valid_i = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            start_i = (k == 10);
            zeroize = (k == 30);
            #1;
            if (k < 30) begin
                check("z_we", dst_we_o, 1);
                check("z_addr", dst_addr_o, k);
            end else begin
                check("z_cut_we", dst_we_o, 0);
                check("z_cut_flush", buf_flush_o, 1);
                check("z_cut_addr", dst_addr_o, 30);
            end
            tick();
        end
        zeroize = 1'b0; start_i = 1'b0; buf_valid_i = 1'b0;
        #1 check("z_idle_busy", busy_o, 0);
        check("z_idle_done", done_o, 0);
        check("z_idle_addr", dst_addr_o, 0);
        tick();
        #1 check("z_idle2_done", done_o, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0; buf_valid_i = 1'b1;
        #1 check("z_restart_we", dst_we_o, 1);
        check("z_restart_addr0", dst_addr_o, 0);
        tick();
        #1 check("z_restart_addr1", dst_addr_o, 1);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0; buf_valid_i = 1'b0;

        // Reset asserted in the middle of RUN.
        start_i = 1'b1;
        tick();
        start_i = 1'b0; src_valid_i = 1'b1; buf_valid_i = 1'b1;
        tick();
        tick();
        #1 check("r_run_busy", busy_o, 1);
        rst_b = 1'b0;
        #1 check("r_src_req", src_req_o, 0);
        check("r_squeeze", squeeze_next_o, 0);
        check("r_flush", buf_flush_o, 0);
        check("r_we", dst_we_o, 0);
        check("r_addr", dst_addr_o, 0);
        check("r_busy", busy_o, 0);
        check("r_done", done_o, 0);
        tick();
        rst_b = 1'b1;
        #1 check("r_rel_busy", busy_o, 0);
        check("r_rel_req", src_req_o, 0);
        tick();
        #1 check("r_rel2_busy", busy_o, 0);
        src_valid_i = 1'b0; buf_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
